// File: rtl/dmem_arbiter_pkg.sv
// Shared controls for the data-memory arbiter: load/store size codes,
// arbiter FSM state type and a size helper.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      LS_BYTE    = 2'd0,
      LS_HALF    = 2'd1,
      LS_WORD    = 2'd2,
      LS_INVALID = 2'd3
   } ls_type_t;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_ACCESS = 1'b1
   } arb_state_t;

   // Access size in bytes; the invalid code has no size
   function automatic logic [2:0] ls_size(input logic [1:0] lst);
      case (ls_type_t'(lst))
         LS_BYTE: return 3'd1;
         LS_HALF: return 3'd2;
         LS_WORD: return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin picker. Port 0 holds priority out of reset; after
// every accepted grant priority passes to the port that was not granted.
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic prio1;

   // One-hot winner selection from the current requests and priority
   always_comb begin
      gnt = '0;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = prio1 ? 2'b10 : 2'b01;
         default: gnt = '0;
      endcase
   end

   // Priority pointer moves away from the port that was just granted
   always_ff @(posedge clk) begin
      if (rst) begin
         prio1 <= 1'b0;
      end else if (advance) begin
         prio1 <= gnt[0];
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core (port 0) and debug/DMA (port 1) share
// one data memory; one access per IDLE/ACCESS pair, with range checking.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_LOCS   = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [1:0]            lst0,
   input  logic                  lsu0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   input  logic [1:0]            lst1,
   input  logic                  lsu1,
   output logic                  gnt0,
   output logic                  rvalid0,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic                  err0,
   output logic                  gnt1,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  err1,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [1:0]            load_store_type,
   output logic                  load_unsigned,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic [15:0]           access_count
);

   localparam logic [ADDR_WIDTH:0] LAST_LEGAL = (ADDR_WIDTH+1)'(4*NUM_LOCS-1);

   arb_state_t            state;
   logic [1:0]            rr_gnt;
   logic                  grant;
   logic                  win;
   logic                  win_we;
   logic                  win_lsu;
   logic [1:0]            win_lst;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_wdata;
   logic [ADDR_WIDTH:0]   win_last;
   logic                  win_err;
   logic                  cap_we;
   logic                  cap_err;
   logic                  cap_owner;
   logic [DATA_WIDTH-1:0] resp_data;

   // Grants only in IDLE and never while reset is asserted
   assign grant = (state == ARB_IDLE) && !rst && (req0 || req1);

   rr_arbiter_2 u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     ({req1, req0}),
      .advance (grant),
      .gnt     (rr_gnt)
   );

   assign gnt0 = grant & rr_gnt[0];
   assign gnt1 = grant & rr_gnt[1];
   assign win  = rr_gnt[1];

   // Winner field mux and range check; last byte is one bit wider so a
   // wrapping address lands out of range
   always_comb begin
      win_we    = win ? we1    : we0;
      win_lsu   = win ? lsu1   : lsu0;
      win_lst   = win ? lst1   : lst0;
      win_addr  = win ? addr1  : addr0;
      win_wdata = win ? wdata1 : wdata0;
      win_last  = {1'b0, win_addr} + (ADDR_WIDTH+1)'(ls_size(win_lst))
                  - (ADDR_WIDTH+1)'(1);
      win_err   = (win_lst == LS_INVALID) || (win_last > LAST_LEGAL);
   end

   assign mem_read  = (state == ARB_ACCESS) && !rst && !cap_we && !cap_err;
   assign mem_write = (state == ARB_ACCESS) && !rst &&  cap_we && !cap_err;
   assign resp_data = (cap_we || cap_err) ? '0 : mem_read_data;

   // Access FSM: capture the winner on grant, respond at the end of ACCESS
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ARB_IDLE;
         cap_we          <= 1'b0;
         cap_err         <= 1'b0;
         cap_owner       <= 1'b0;
         mem_addr        <= '0;
         mem_write_data  <= '0;
         load_store_type <= '0;
         load_unsigned   <= 1'b0;
         rvalid0         <= 1'b0;
         rvalid1         <= 1'b0;
         rdata0          <= '0;
         rdata1          <= '0;
         err0            <= 1'b0;
         err1            <= 1'b0;
         access_count    <= '0;
      end else begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (grant) begin
                  cap_we          <= win_we;
                  cap_err         <= win_err;
                  cap_owner       <= win;
                  mem_addr        <= win_addr;
                  mem_write_data  <= win_wdata;
                  load_store_type <= win_lst;
                  load_unsigned   <= win_lsu;
                  if (access_count != 16'hFFFF) begin
                     access_count <= access_count + 16'd1;
                  end
                  state <= ARB_ACCESS;
               end
            end
            ARB_ACCESS: begin
               if (cap_owner) begin
                  rvalid1 <= 1'b1;
                  rdata1  <= resp_data;
                  err1    <= cap_err;
               end else begin
                  rvalid0 <= 1'b1;
                  rdata0  <= resp_data;
                  err0    <= cap_err;
               end
               state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: per-port drivers, a byte-addressed
// data memory, and a transaction-level reference model checked every cycle.
module tb_dmem_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int NL   = 64;
   localparam int MEMB = 4 * NL;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  lst;
      logic        lsu;
   } txn_t;

   typedef struct {
      int          due;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req   [2];
   logic        we    [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [1:0]  lst   [2];
   logic        lsu   [2];

   logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic [31:0] mem_addr, mem_write_data, mem_read_data;
   logic        mem_read, mem_write, load_unsigned;
   logic [1:0]  load_store_type;
   logic [15:0] access_count;

   logic        gnt_a    [2];
   logic        rvalid_a [2];
   logic        err_a    [2];
   logic [31:0] rdata_a  [2];

   int checks = 0;
   int errors = 0;

   txn_t txq  [2][$];
   exp_t expq [2][$];
   logic [7:0] envmem [MEMB];
   logic [7:0] refmem [MEMB];

   // model state
   int          cyc = 0;
   logic        busy = 1'b0;
   txn_t        pend;
   int          pport = 0;
   logic        pend_err = 1'b0;
   logic        prio1 = 1'b0;
   int          mcount = 0;
   logic [31:0] mrd [2];
   logic        mer [2];
   logic        mw_seen = 1'b0;
   int          rv_cnt [2];
   int          rv_cyc [2];
   logic [31:0] last_rd [2];
   logic        last_er [2];
   int          glog_p [$];
   int          glog_c [$];

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LOCS(NL)) dut (
      .clk(clk), .rst(rst),
      .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
      .lst0(lst[0]), .lsu0(lsu[0]),
      .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
      .lst1(lst[1]), .lsu1(lsu[1]),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_write(mem_write),
      .load_store_type(load_store_type), .load_unsigned(load_unsigned),
      .mem_read_data(mem_read_data), .access_count(access_count)
   );

   always_comb begin
      gnt_a[0] = gnt0;       gnt_a[1] = gnt1;
      rvalid_a[0] = rvalid0; rvalid_a[1] = rvalid1;
      err_a[0] = err0;       err_a[1] = err1;
      rdata_a[0] = rdata0;   rdata_a[1] = rdata1;
   end

   function automatic int unsigned size_of(input logic [1:0] l);
      case (l)
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] raw, input int unsigned sz,
                                          input logic uns);
      case (sz)
         1:       return uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         2:       return uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   function automatic logic range_err(input logic [31:0] a, input logic [1:0] l);
      longint last;
      if (l == 2'd3) return 1'b1;
      last = longint'({32'b0, a}) + longint'(size_of(l)) - 1;
      return last > longint'(MEMB - 1);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // data memory seen by the DUT: little-endian bytes, sign handling on load
   always_comb begin
      logic [31:0] raw;
      raw = '0;
      for (int unsigned i = 0; i < 4; i++)
         if (i < size_of(load_store_type)) raw[8*i +: 8] = envmem[8'(mem_addr + i)];
      mem_read_data = extend(raw, size_of(load_store_type), load_unsigned);
   end

   always @(posedge clk)
      if (mem_write)
         for (int unsigned i = 0; i < 4; i++)
            if (i < size_of(load_store_type))
               envmem[8'(mem_addr + i)] <= mem_write_data[8*i +: 8];

   // reference model + monitor, sampled on the falling edge
   always @(negedge clk) begin
      logic was_busy;
      logic exp_rv;
      int   win;
      exp_t e;
      logic [31:0] raw;
      cyc++;
      if (mem_write) mw_seen = 1'b1;
      if (rst) begin
         chk("gnt_in_reset", 64'({gnt1, gnt0}), 64'd0);
         chk("memrw_in_reset", 64'({mem_read, mem_write}), 64'd0);
         busy = 1'b0; prio1 = 1'b0; mcount = 0;
         for (int p = 0; p < 2; p++) begin
            expq[p].delete(); mrd[p] = '0; mer[p] = 1'b0;
         end
      end else begin
         chk("access_count", 64'(access_count), 64'(mcount));
         if (busy) begin
            chk("mem_rd_wr", 64'({mem_read, mem_write}),
                64'({~pend.we & ~pend_err, pend.we & ~pend_err}));
            chk("mem_addr", 64'(mem_addr), 64'(pend.addr));
            chk("mem_lst", 64'({load_store_type, load_unsigned}), 64'({pend.lst, pend.lsu}));
            if (pend.we) chk("mem_wdata", 64'(mem_write_data), 64'(pend.wdata));
         end else begin
            chk("mem_rd_wr_idle", 64'({mem_read, mem_write}), 64'd0);
         end
         for (int p = 0; p < 2; p++) begin
            exp_rv = (expq[p].size() > 0) && (expq[p][0].due == cyc);
            if (exp_rv || rvalid_a[p]) begin
               chk($sformatf("rvalid%0d", p), 64'(rvalid_a[p]), 64'(exp_rv));
               if (exp_rv) begin
                  e = expq[p].pop_front();
                  if (rvalid_a[p]) begin
                     chk($sformatf("rdata%0d", p), 64'(rdata_a[p]), 64'(e.rdata));
                     chk($sformatf("err%0d", p), 64'(err_a[p]), 64'(e.err));
                     last_rd[p] = rdata_a[p]; last_er[p] = err_a[p];
                     rv_cnt[p]++; rv_cyc[p] = cyc;
                  end
                  mrd[p] = e.rdata; mer[p] = e.err;
               end
            end else begin
               chk($sformatf("hold%0d", p), 64'({err_a[p], rdata_a[p]}), 64'({mer[p], mrd[p]}));
            end
         end
         was_busy = busy;
         if (busy) begin
            e.due = cyc + 1; e.err = pend_err; e.rdata = '0;
            if (!pend_err && pend.we) begin
               for (int unsigned i = 0; i < size_of(pend.lst); i++)
                  refmem[8'(pend.addr + i)] = pend.wdata[8*i +: 8];
            end else if (!pend_err) begin
               raw = '0;
               for (int unsigned i = 0; i < size_of(pend.lst); i++)
                  raw[8*i +: 8] = refmem[8'(pend.addr + i)];
               e.rdata = extend(raw, size_of(pend.lst), pend.lsu);
            end
            expq[pport].push_back(e);
            busy = 1'b0;
         end
         if (!was_busy && (req[0] || req[1])) begin
            win = (req[0] && req[1]) ? (prio1 ? 1 : 0) : (req[1] ? 1 : 0);
            chk("gnt", 64'({gnt1, gnt0}), (win == 1) ? 64'd2 : 64'd1);
            pend = '{we: we[win], addr: addr[win], wdata: wdata[win], lst: lst[win], lsu: lsu[win]};
            pport = win;
            pend_err = range_err(addr[win], lst[win]);
            busy = 1'b1;
            prio1 = (win == 0);
            if (mcount < 65535) mcount++;
            glog_p.push_back(win);
            glog_c.push_back(cyc);
         end else begin
            chk("gnt_none", 64'({gnt1, gnt0}), 64'd0);
         end
      end
   end

   task automatic drive_port(input int p);
      logic granted;
      int   waitc;
      txn_t t;
      granted = 1'b0;
      waitc = 0;
      forever begin
         @(posedge clk); #1;
         if (granted) begin req[p] = 1'b0; granted = 1'b0; end
         if (!req[p] && !rst && txq[p].size() > 0) begin
            t = txq[p].pop_front();
            we[p] = t.we; addr[p] = t.addr; wdata[p] = t.wdata; lst[p] = t.lst; lsu[p] = t.lsu;
            req[p] = 1'b1;
            waitc = 0;
         end
         if (req[p]) begin
            @(negedge clk);
            if (gnt_a[p]) granted = 1'b1;
            else begin
               waitc++;
               if (waitc > 50) begin
                  chk($sformatf("grant_timeout%0d", p), 64'd0, 64'd1);
                  granted = 1'b1;
               end
            end
         end
      end
   endtask

   initial drive_port(0);
   initial drive_port(1);

   task automatic push(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] l, input logic u);
      txq[p].push_back('{we: w, addr: a, wdata: d, lst: l, lsu: u});
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((txq[0].size() > 0 || txq[1].size() > 0 || req[0] || req[1] || busy ||
              expq[0].size() > 0 || expq[1].size() > 0) && n < 1000) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 1000) chk("drain_timeout", 64'd0, 64'd1);
      @(negedge clk); #1;
   endtask

   function automatic txn_t rand_txn();
      txn_t t;
      t.we    = 1'($urandom_range(0, 1));
      t.addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, MEMB + 3));
      t.wdata = $urandom;
      t.lst   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      t.lsu   = 1'($urandom_range(0, 1));
      return t;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      int rv_before;
      txn_t t;
      for (int p = 0; p < 2; p++) begin
         req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0; lst[p] = '0; lsu[p] = 1'b0;
         mrd[p] = '0; mer[p] = 1'b0; rv_cnt[p] = 0; rv_cyc[p] = 0;
         last_rd[p] = '0; last_er[p] = 1'b0;
      end
      for (int i = 0; i < MEMB; i++) begin envmem[i] = '0; refmem[i] = '0; end

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_rvalid", 64'({rvalid1, rvalid0}), 64'd0);
      chk("reset_err", 64'({err1, err0}), 64'd0);
      chk("reset_rdata", 64'({rdata1, rdata0}), 64'd0);
      chk("reset_count", 64'(access_count), 64'd0);
      chk("reset_mem_addr", 64'(mem_addr), 64'd0);
      chk("reset_mem_wdata", 64'(mem_write_data), 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      // both ports requesting continuously: strict alternation from port 0
      glog_p.delete(); glog_c.delete();
      push(0, 1'b0, 32'h00, '0, 2'd2, 1'b0); push(0, 1'b0, 32'h08, '0, 2'd2, 1'b0);
      push(1, 1'b0, 32'h04, '0, 2'd2, 1'b0); push(1, 1'b0, 32'h0C, '0, 2'd2, 1'b0);
      wait_idle();
      chk("rr_grants", 64'(glog_p.size()), 64'd4);
      if (glog_p.size() == 4) begin
         chk("rr_order", 64'({glog_p[0][1:0], glog_p[1][1:0], glog_p[2][1:0], glog_p[3][1:0]}),
             64'h11);
         chk("rr_spacing", 64'(glog_c[3] - glog_c[0]), 64'd6);
      end
      chk("rr_count", 64'(access_count), 64'd4);

      // reset during the ACCESS of a store: no write, no response, count cleared
      mw_seen = 1'b0;
      rv_before = rv_cnt[0];
      push(0, 1'b1, 32'h10, 32'h12345678, 2'd2, 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (!gnt0 && n < 50);
      chk("rst_store_granted", 64'(gnt0), 64'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_count_zero", 64'(access_count), 64'd0);
      repeat (4) @(negedge clk);
      chk("rst_no_write", 64'(mw_seen), 64'd0);
      chk("rst_no_rvalid", 64'(rv_cnt[0]), 64'(rv_before));
      push(0, 1'b0, 32'h10, '0, 2'd2, 1'b0);
      wait_idle();
      chk("rst_load_zero", 64'(last_rd[0]), 64'd0);

      // word store then load on port 0: grants two apart, data four after first
      glog_p.delete(); glog_c.delete();
      push(0, 1'b1, 32'h40, 32'hDEADBEEF, 2'd2, 1'b0);
      push(0, 1'b0, 32'h40, '0, 2'd2, 1'b0);
      wait_idle();
      if (glog_c.size() == 2) begin
         chk("st_ld_gap", 64'(glog_c[1] - glog_c[0]), 64'd2);
         chk("st_ld_latency", 64'(rv_cyc[0] - glog_c[0]), 64'd4);
      end else chk("st_ld_grants", 64'(glog_c.size()), 64'd2);
      chk("st_ld_data", 64'(last_rd[0]), 64'hDEADBEEF);
      chk("st_ld_err", 64'(last_er[0]), 64'd0);

      // byte 0x80 at 0x43: signed, unsigned and straddling half loads
      push(0, 1'b1, 32'h43, 32'h00000080, 2'd0, 1'b0); wait_idle();
      push(0, 1'b0, 32'h43, '0, 2'd0, 1'b0); wait_idle();
      chk("lb_signed", 64'(last_rd[0]), 64'hFFFFFF80);
      push(0, 1'b0, 32'h43, '0, 2'd0, 1'b1); wait_idle();
      chk("lb_unsigned", 64'(last_rd[0]), 64'h00000080);
      push(0, 1'b0, 32'h43, '0, 2'd1, 1'b1); wait_idle();
      chk("lh_straddle_lo", 64'(last_rd[0][7:0]), 64'h80);
      chk("lh_straddle_hi", 64'(last_rd[0][31:16]), 64'd0);

      // range and code errors, plus the last legal word
      push(1, 1'b0, 32'hFE, '0, 2'd2, 1'b0); wait_idle();
      chk("err_word_fe", 64'({last_er[1], last_rd[1]}), 64'h1_0000_0000);
      push(1, 1'b0, 32'hFC, '0, 2'd2, 1'b0); wait_idle();
      chk("ok_word_fc", 64'(last_er[1]), 64'd0);
      push(1, 1'b0, 32'h00, '0, 2'd3, 1'b0); wait_idle();
      chk("err_lst3", 64'({last_er[1], last_rd[1]}), 64'h1_0000_0000);
      push(0, 1'b1, 32'hFFFFFFFE, 32'hCAFEF00D, 2'd2, 1'b0); wait_idle();
      chk("err_wrap_store", 64'(last_er[0]), 64'd1);
      push(0, 1'b1, 32'hFF, 32'h000000A5, 2'd0, 1'b0); wait_idle();
      chk("ok_byte_ff", 64'(last_er[0]), 64'd0);

      // randomized contention bursts
      for (int b = 0; b < 25; b++) begin
         for (int p = 0; p < 2; p++) begin
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin
               t = rand_txn();
               txq[p].push_back(t);
            end
         end
         wait_idle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the request and memory address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data width.
REQ-003 Parameter NUM_LOCS, default 64, SHALL give the data memory size in 32-bit words and bound the legal byte range 0..4*NUM_LOCS-1.
REQ-004 Ports, in this order:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- reqN  in  1  port N access request (N = 0 core, N = 1 debug/DMA).
- weN  in  1  port N store (1) or load (0).
- addrN  in  ADDR_WIDTH  port N byte address.
- wdataN  in  DATA_WIDTH  port N store data.
- lstN  in  2  port N load/store type.
- lsuN  in  1  port N unsigned-load flag.
- gntN  out  1  port N request accepted.
- rvalidN  out  1  port N response valid.
- rdataN  out  DATA_WIDTH  port N load data.
- errN  out  1  port N access error.
- mem_addr  out  ADDR_WIDTH  to data memory.
- mem_write_data  out  DATA_WIDTH  to data memory.
- mem_read, mem_write  out  1 each  to data memory.
- load_store_type  out  2  to data memory.
- load_unsigned  out  1  to data memory.
- mem_read_data  in  DATA_WIDTH  combinational read data from data memory.
- access_count  out  16  accepted-access counter.

Function
REQ-005 The FSM SHALL have two states: IDLE and ACCESS.
REQ-006 In IDLE with any reqN high, gnt SHALL assert combinationally to exactly one winner; the winner's fields SHALL be captured at the clock edge; next state SHALL be ACCESS.
REQ-007 Arbitration:
- single requester wins;
- both requesting: the port not granted last wins (round-robin);
- after reset, port 0 holds priority.
REQ-008 Requesters SHALL hold reqN and its fields stable until gntN; gntN SHALL be a one-cycle pulse; gnt SHALL never assert in ACCESS.
REQ-009 In ACCESS, memory outputs SHALL come from the captured request: mem_read = ~we & ~err, mem_write = we & ~err; next state SHALL be IDLE.
REQ-010 In IDLE, mem_read and mem_write SHALL be 0 and mem_addr/mem_write_data SHALL hold their last values.
REQ-011 At the end of ACCESS, the owner's rdataN, errN and rvalidN SHALL be registered.
- rvalidN is a one-cycle pulse two cycles after gntN.
- rdataN = mem_read_data for loads; 0 for stores or errors.
REQ-012 An error SHALL be flagged when either condition holds:
- lst = 2'b11;
- addr + size - 1 > 4*NUM_LOCS - 1, where size is 1/2/4 for byte/half/word, computed in ADDR_WIDTH+1 bits so address wrap-around counts as out of range.
REQ-013 Unaligned in-range accesses SHALL be legal and passed through.
REQ-014 A new grant MAY coincide with the previous rvalid, giving a peak of one access per two cycles.
REQ-015 access_count SHALL increment on every grant, including errored ones, and saturate at 16'hFFFF.
REQ-016 The rdataN and errN of the non-owning port SHALL hold their previous values.

Reset
REQ-017 While rst is high, at the edge:
- state -> IDLE, round-robin pointer -> port 0 first;
- gnt, rvalid and err outputs -> 0, rdata -> 0, access_count -> 0;
- mem_addr, mem_write_data and captured fields -> 0.
REQ-018 While rst is high, mem_read, mem_write and gntN SHALL be forced 0 combinationally, so reset asserted during ACCESS causes no memory write and no response.

Structure
REQ-019 The LS codes (BYTE=0, HALF=1, WORD=2, INVALID=3) and the arb_state_t typedef SHALL live in the shared controls package.
REQ-020 The two-way round-robin picker SHALL be a sub-module, rr_arbiter_2, with inputs req[1:0] and advance and output gnt[1:0].

Verification
REQ-021 Port 0 issues a word store of 32'hDEADBEEF at 0x40, then a word load at 0x40 -> gnt0 at T and T+2; rvalid0 at T+4 with rdata0 = 32'hDEADBEEF and err0 = 0.
REQ-022 Both ports hold a request continuously after reset -> grants alternate 0,1,0,1 on every second cycle; access_count = 4 after four grants.
REQ-023 Byte 8'h80 stored at 0x43; signed byte load -> 32'hFFFFFF80; unsigned byte load -> 32'h00000080; half load at 0x43 -> 16'h??80 assembled across the word boundary.
REQ-024 Word load at 0xFE with NUM_LOCS = 64, and any access with lst = 3 -> err = 1, rdata = 0, mem_read/mem_write stay 0; a store at 0xFFFFFFFE -> err = 1.
REQ-025 rst pulsed during the ACCESS of a store of 32'h12345678 at 0x10 -> mem_write never observed high, no rvalid, later load of 0x10 returns 0, access_count = 0.
